// File: rtl/i2c_slave_monitor_apb.sv
// i2c_slave_monitor_apb
//   Instrumented I2C slave used to exercise an external I2C master. It
//   decodes START/STOP, ACKs its own address and the bytes written to it,
//   and returns an incrementing byte stream on reads. Bus activity and data
//   checksums are counted into byte registers readable over APB2.
// Ports:
//   clk, rst            system clock, asynchronous active-low reset
//   logical_in          pin levels: [0] SDA, [1] SCL
//   val, drive          open-drain pin control: val is always 0, drive[0]
//                       pulls SDA low, no other bit is ever asserted
//   PADDR..PRDATA       APB2 slave port, zero wait states, combinational read
module i2c_slave_monitor_apb #(
    parameter int IO_LOGICAL = 8,
    parameter int ADDR_BITS  = 12,
    parameter int DATA_BITS  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IO_LOGICAL-1:0] logical_in,
    output logic [IO_LOGICAL-1:0] val,
    output logic [IO_LOGICAL-1:0] drive,
    input  logic [ADDR_BITS-1:0]  PADDR,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [DATA_BITS-1:0]  PWDATA,
    output logic [DATA_BITS-1:0]  PRDATA
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_ADDR = 3'd1, S_ADDR_ACK = 3'd2, S_WR = 3'd3,
        S_WR_ACK = 3'd4, S_RD = 3'd5, S_RD_ACK = 3'd6
    } state_t;

    // Synchronizer chains: [0] metastable stage, [1] synced level, [2] previous level.
    logic [2:0] sda_sync_q, scl_sync_q;
    logic sda_s, scl_s, sda_rise, sda_fall, scl_rise, scl_fall, start_det, stop_det;

    state_t           state_q, state_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d, tx_q, tx_d, shift_in;
    logic             sda_oe_q, sda_oe_d, hold_q, hold_d;
    logic [7:0]       starts_q, starts_d, stops_q, stops_d, matches_q, matches_d, nfs_q, nfs_d;
    logic [15:0]      acks_q, acks_d, nacks_q, nacks_d, transfers_q, transfers_d;
    logic [15:0]      num_writes_q, num_writes_d, num_reads_q, num_reads_d, dev_addr_q, dev_addr_d;
    logic [31:0]      to_cs_q, to_cs_d, from_cs_q, from_cs_d;
    logic [3:0][7:0]  prev_q, prev_d;   // [0] = newest byte written to the slave
    logic             test_mode_q, test_mode_d;
    logic             reg_hit, apb_wr;
    logic [7:0]       rd_byte;
    logic             unused_pins;

    assign unused_pins = ^{logical_in[IO_LOGICAL-1:2], PWDATA};

    // The bus idles high, so the chains reset to 1: releasing reset on an idle
    // bus must not look like a rising edge (which would read as a STOP).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sda_sync_q <= '1;
            scl_sync_q <= '1;
        end else begin
            // NOTE: clocked state uses <= so every flop samples pre-edge values.
            sda_sync_q <= {sda_sync_q[1:0], logical_in[0]};
            scl_sync_q <= {scl_sync_q[1:0], logical_in[1]};
        end
    end

    assign sda_s     = sda_sync_q[1];
    assign scl_s     = scl_sync_q[1];
    assign sda_rise  = sda_s & ~sda_sync_q[2];
    assign sda_fall  = ~sda_s & sda_sync_q[2];
    assign scl_rise  = scl_s & ~scl_sync_q[2];
    assign scl_fall  = ~scl_s & scl_sync_q[2];
    assign start_det = sda_fall & scl_s;
    assign stop_det  = sda_rise & scl_s;
    assign shift_in  = {shift_q[6:0], sda_s};
    assign reg_hit   = (PADDR[ADDR_BITS-1:5] == '0);
    assign apb_wr    = PSEL & PENABLE & PWRITE & reg_hit;

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_d = state_q;   bit_cnt_d = bit_cnt_q;     shift_d = shift_q;   tx_d = tx_q;
        sda_oe_d = sda_oe_q; hold_d = hold_q;           starts_d = starts_q; stops_d = stops_q;
        acks_d = acks_q;     nacks_d = nacks_q;         transfers_d = transfers_q;
        to_cs_d = to_cs_q;   from_cs_d = from_cs_q;     matches_d = matches_q;
        num_writes_d = num_writes_q; num_reads_d = num_reads_q; prev_d = prev_q;
        dev_addr_d = dev_addr_q; test_mode_d = test_mode_q; nfs_d = nfs_q;

        // Statistics are frozen while the bus is being held (test_mode = 0).
        if (stop_det) begin
            state_d  = S_IDLE;
            sda_oe_d = 1'b0;
            hold_d   = 1'b0;
            if (test_mode_q) stops_d = stops_q + 8'd1;
        end else if (start_det) begin
            state_d   = S_ADDR;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            hold_d    = 1'b1;
            if (test_mode_q) starts_d = starts_q + 8'd1;
        end else begin
            case (state_q)
                S_ADDR: begin
                    if (scl_rise && bit_cnt_q != 4'd8) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7 && test_mode_q) transfers_d = transfers_q + 16'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        if ({shift_q[7:1], 1'b0} == dev_addr_q[7:0]) begin
                            state_d  = S_ADDR_ACK;
                            sda_oe_d = 1'b1;
                            if (test_mode_q) begin
                                matches_d = matches_q + 8'd1;
                                acks_d    = acks_q + 16'd1;
                            end
                        end else begin
                            state_d = S_IDLE;
                            if (test_mode_q) nacks_d = nacks_q + 16'd1;
                        end
                    end
                end
                // ACK states are entered on an SCL fall, so the next fall seen
                // is the one that closes the ACK clock.
                S_ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_d = '0;
                        if (shift_q[0]) begin
                            state_d  = S_RD;
                            tx_d     = nfs_q;
                            sda_oe_d = ~nfs_q[7];
                        end else begin
                            state_d  = S_WR;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                S_WR: begin
                    if (scl_rise && bit_cnt_q != 4'd8) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7 && test_mode_q) begin
                            transfers_d  = transfers_q + 16'd1;
                            num_writes_d = num_writes_q + 16'd1;
                            to_cs_d      = to_cs_q + {24'd0, shift_in};
                            prev_d       = {prev_q[2:0], shift_in};
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        state_d  = S_WR_ACK;
                        sda_oe_d = 1'b1;
                        if (test_mode_q) acks_d = acks_q + 16'd1;
                    end
                end
                S_WR_ACK: begin
                    if (scl_fall) begin
                        state_d   = S_WR;
                        bit_cnt_d = '0;
                        sda_oe_d  = 1'b0;
                    end
                end
                S_RD: begin
                    if (scl_rise && bit_cnt_q != 4'd8) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7 && test_mode_q) begin
                            transfers_d = transfers_q + 16'd1;
                            num_reads_d = num_reads_q + 16'd1;
                            from_cs_d   = from_cs_q + {24'd0, tx_q};
                            nfs_d       = nfs_q + 8'd1;
                        end
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            state_d  = S_RD_ACK;
                            sda_oe_d = 1'b0;
                        end else begin
                            // After k bits the next one out is bit 7-k, i.e. ~k in 3 bits.
                            sda_oe_d = ~tx_q[~bit_cnt_q[2:0]];
                        end
                    end
                end
                S_RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_s) begin
                            state_d = S_IDLE;
                            if (test_mode_q) nacks_d = nacks_q + 16'd1;
                        end else if (test_mode_q) begin
                            acks_d = acks_q + 16'd1;
                        end
                    end else if (scl_fall) begin
                        state_d   = S_RD;
                        bit_cnt_d = '0;
                        tx_d      = nfs_q;
                        sda_oe_d  = ~nfs_q[7];
                    end
                end
                default: ;
            endcase
        end

        // Applied last so an APB write overrides a same-cycle bus update.
        if (apb_wr) begin
            case (PADDR[4:0])
                5'd14:   dev_addr_d[7:0]  = PWDATA[7:0];
                5'd15:   dev_addr_d[15:8] = PWDATA[7:0];
                5'd16:   test_mode_d      = PWDATA[0];
                5'd21:   nfs_d            = PWDATA[7:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;  bit_cnt_q <= '0;  shift_q <= '0;  tx_q <= '0;
            sda_oe_q <= 1'b0;   hold_q <= 1'b0;   starts_q <= '0; stops_q <= '0;
            acks_q <= '0;       nacks_q <= '0;    transfers_q <= '0;
            to_cs_q <= '0;      from_cs_q <= '0;  matches_q <= '0;
            num_writes_q <= '0; num_reads_q <= '0; prev_q <= '0;
            dev_addr_q <= 16'h0098; test_mode_q <= 1'b1; nfs_q <= '0;
        end else begin
            state_q <= state_d;   bit_cnt_q <= bit_cnt_d; shift_q <= shift_d; tx_q <= tx_d;
            sda_oe_q <= sda_oe_d; hold_q <= hold_d;       starts_q <= starts_d; stops_q <= stops_d;
            acks_q <= acks_d;     nacks_q <= nacks_d;     transfers_q <= transfers_d;
            to_cs_q <= to_cs_d;   from_cs_q <= from_cs_d; matches_q <= matches_d;
            num_writes_q <= num_writes_d; num_reads_q <= num_reads_d; prev_q <= prev_d;
            dev_addr_q <= dev_addr_d; test_mode_q <= test_mode_d; nfs_q <= nfs_d;
        end
    end

    // Bus-hold mode pulls SDA low for the whole START..STOP window.
    always_comb begin
        drive    = '0;
        drive[0] = test_mode_q ? sda_oe_q : hold_q;
    end
    assign val = '0;

    always_comb begin
        rd_byte = '0;
        if (reg_hit) begin
            case (PADDR[4:0])
                5'd0:  rd_byte = starts_q;
                5'd1:  rd_byte = stops_q;
                5'd2:  rd_byte = acks_q[7:0];
                5'd3:  rd_byte = acks_q[15:8];
                5'd4:  rd_byte = nacks_q[7:0];
                5'd5:  rd_byte = nacks_q[15:8];
                5'd6:  rd_byte = transfers_q[7:0];
                5'd7:  rd_byte = transfers_q[15:8];
                5'd8:  rd_byte = to_cs_q[7:0];
                5'd9:  rd_byte = to_cs_q[15:8];
                5'd10: rd_byte = to_cs_q[23:16];
                5'd11: rd_byte = to_cs_q[31:24];
                5'd12: rd_byte = {5'd0, state_q};
                5'd13: rd_byte = matches_q;
                5'd14: rd_byte = dev_addr_q[7:0];
                5'd15: rd_byte = dev_addr_q[15:8];
                5'd16: rd_byte = {7'd0, test_mode_q};
                5'd17: rd_byte = prev_q[3];
                5'd18: rd_byte = prev_q[2];
                5'd19: rd_byte = prev_q[1];
                5'd20: rd_byte = prev_q[0];
                5'd21: rd_byte = nfs_q;
                5'd22: rd_byte = num_writes_q[7:0];
                5'd23: rd_byte = num_writes_q[15:8];
                5'd24: rd_byte = num_reads_q[7:0];
                5'd25: rd_byte = num_reads_q[15:8];
                5'd26: rd_byte = from_cs_q[7:0];
                5'd27: rd_byte = from_cs_q[15:8];
                5'd28: rd_byte = from_cs_q[23:16];
                5'd29: rd_byte = from_cs_q[31:24];
                default: rd_byte = '0;
            endcase
        end
    end
    assign PRDATA = DATA_BITS'(rd_byte);

endmodule

// File: tb/tb_i2c_slave_monitor_apb.sv
// Testbench for i2c_slave_monitor_apb. A behavioural I2C master drives the
// pins; logical_in carries the level the master itself drives, and the bench
// resolves the open-drain wire-AND (master & ~drive) for what the master
// receives. A transaction-level model tracks the expected register values.
`timescale 1ns/1ps
module tb_i2c_slave_monitor_apb;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        m_sda = 1'b1, m_scl = 1'b1;
    logic [7:0]  logical_in, val, drive;
    logic [11:0] PADDR = '0;
    logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [7:0]  PWDATA = '0, PRDATA;

    assign logical_in = {6'b0, m_scl, m_sda};
    always #5 clk = ~clk;

    i2c_slave_monitor_apb dut (
        .clk(clk), .rst(rst), .logical_in(logical_in), .val(val), .drive(drive),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PRDATA(PRDATA)
    );

    int n_tests = 0, n_fail = 0;
    int q = 10;                       // quarter SCL period in clk cycles
    int q_tab [3] = '{16, 10, 6};     // scaled 100 kHz / 400 kHz / 1 MHz
    logic drive_seen;
    logic [7:0] data_buf [16];

    // Transaction-level model of the register file.
    int unsigned m_starts, m_stops, m_acks, m_nacks, m_transfers, m_to_cs, m_from_cs;
    int unsigned m_matches, m_writes, m_reads;
    logic [15:0] m_dev;
    logic        m_tm;
    logic [7:0]  m_nfs;
    logic [7:0]  m_prev [4];          // [0] = newest

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_starts = 0; m_stops = 0; m_acks = 0; m_nacks = 0; m_transfers = 0;
        m_to_cs = 0; m_from_cs = 0; m_matches = 0; m_writes = 0; m_reads = 0;
        m_dev = 16'h0098; m_tm = 1'b1; m_nfs = 8'h00;
        for (int i = 0; i < 4; i++) m_prev[i] = 8'h00;
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apb_write(input logic [11:0] a, input logic [7:0] d);
        PSEL = 1'b1; PWRITE = 1'b1; PADDR = a; PWDATA = d; PENABLE = 1'b0;
        @(negedge clk);
        PENABLE = 1'b1;
        @(negedge clk);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [11:0] a, output logic [7:0] d);
        PSEL = 1'b1; PWRITE = 1'b0; PADDR = a; PENABLE = 1'b0;
        @(negedge clk);
        PENABLE = 1'b1;
        #1 d = PRDATA;
        @(negedge clk);
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic rd_field(input logic [11:0] a, input int n, output logic [31:0] v);
        logic [7:0] b;
        v = '0;
        for (int i = 0; i < n; i++) begin
            apb_read(a + 12'(i), b);
            v = v | (32'(b) << (8 * i));
        end
    endtask

    task automatic check_regs(input string tag);
        logic [31:0] v;
        rd_field(0, 1, v);  check({tag, ".starts"}, v, m_starts & 32'hff);
        rd_field(1, 1, v);  check({tag, ".stops"}, v, m_stops & 32'hff);
        rd_field(2, 2, v);  check({tag, ".acks"}, v, m_acks & 32'hffff);
        rd_field(4, 2, v);  check({tag, ".nacks"}, v, m_nacks & 32'hffff);
        rd_field(6, 2, v);  check({tag, ".transfers"}, v, m_transfers & 32'hffff);
        rd_field(8, 4, v);  check({tag, ".to_cs"}, v, m_to_cs);
        rd_field(12, 1, v); check({tag, ".state"}, v, 32'd0);
        rd_field(13, 1, v); check({tag, ".matches"}, v, m_matches & 32'hff);
        rd_field(14, 2, v); check({tag, ".dev_addr"}, v, 32'(m_dev));
        rd_field(16, 1, v); check({tag, ".test_mode"}, v, 32'(m_tm));
        for (int i = 0; i < 4; i++) begin
            rd_field(12'(17 + i), 1, v);
            check({tag, ".prev"}, v, 32'(m_prev[3 - i]));
        end
        rd_field(21, 1, v); check({tag, ".next_from_slave"}, v, 32'(m_nfs));
        rd_field(22, 2, v); check({tag, ".num_writes"}, v, m_writes & 32'hffff);
        rd_field(24, 2, v); check({tag, ".num_reads"}, v, m_reads & 32'hffff);
        rd_field(26, 4, v); check({tag, ".from_cs"}, v, m_from_cs);
        rd_field(30, 1, v); check({tag, ".unmapped"}, v, 32'd0);
    endtask

    // ---------------- I2C master ----------------
    task automatic i2c_bit(input logic b, output logic r);
        m_sda = b;
        wait_clk(q);
        m_scl = 1'b1;
        wait_clk(q);
        r = m_sda & ~drive[0];
        drive_seen = drive_seen | drive[0];
        wait_clk(q);
        m_scl = 1'b0;
        wait_clk(q);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; m_scl = 1'b1; wait_clk(q);
        m_sda = 1'b0; wait_clk(q);
        m_scl = 1'b0; wait_clk(q);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; wait_clk(q);
        m_scl = 1'b1; wait_clk(q);
        m_sda = 1'b1; wait_clk(2 * q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) i2c_bit(b[i], r);
        i2c_bit(1'b1, r);
        ack = ~r;
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic r;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            i2c_bit(1'b1, r);
            d = {d[6:0], r};
        end
        i2c_bit(nack, r);
    endtask

    // Address phase shared by both transaction kinds; returns the match.
    task automatic addr_phase(input logic [7:0] a, output logic match);
        logic ack;
        i2c_start();
        m_starts++;
        write_byte(a, ack);
        match = ({a[7:1], 1'b0} == m_dev[7:0]);
        check("addr_ack", ack, match);
        m_transfers++;
        if (match) begin m_matches++; m_acks++; end
        else m_nacks++;
    endtask

    task automatic txn_write(input logic [7:0] a, input int n);
        logic match, ack;
        addr_phase(a, match);
        if (match) begin
            for (int i = 0; i < n; i++) begin
                write_byte(data_buf[i], ack);
                check("wr_ack", ack, 1'b1);
                m_transfers++; m_writes++; m_acks++;
                m_to_cs += data_buf[i];
                m_prev[3] = m_prev[2]; m_prev[2] = m_prev[1];
                m_prev[1] = m_prev[0]; m_prev[0] = data_buf[i];
            end
        end else begin
            write_byte(data_buf[0], ack);
            check("ignored_ack", ack, 1'b0);
        end
        i2c_stop();
        m_stops++;
    endtask

    task automatic txn_read(input logic [7:0] a, input int n);
        logic match;
        logic [7:0] d;
        addr_phase(a, match);
        if (match) begin
            for (int i = 0; i < n; i++) begin
                read_byte(i == n - 1, d);
                check("rd_data", d, m_nfs);
                m_transfers++; m_reads++;
                m_from_cs += m_nfs;
                m_nfs = m_nfs + 8'd1;
                if (i == n - 1) m_nacks++; else m_acks++;
            end
        end
        i2c_stop();
        m_stops++;
    endtask

    task automatic pulse_reset();
        rst = 1'b0; wait_clk(3);
        rst = 1'b1; wait_clk(3);
        model_reset();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        logic [7:0]  b, a;
        logic        ack;
        int          n;

        model_reset();
        drive_seen = 1'b0;
        wait_clk(4);
        check("reset_drive", drive, 8'h00);
        check("reset_val", val, 8'h00);
        rst = 1'b1;
        wait_clk(4);
        check_regs("reset");

        // Directed write of 0..9 then read of 10 bytes from 0x32.
        q = q_tab[$urandom_range(0, 2)];
        for (int i = 0; i < 10; i++) data_buf[i] = 8'(i);
        txn_write(8'h98, 10);
        apb_write(21, 8'h32);
        m_nfs = 8'h32;
        txn_read(8'h99, 10);
        check_regs("plan");
        rd_field(2, 2, v);  check("plan.acks_lit", v, 32'd21);
        rd_field(6, 2, v);  check("plan.transfers_lit", v, 32'd22);
        rd_field(8, 4, v);  check("plan.to_cs_lit", v, 32'd45);
        rd_field(26, 4, v); check("plan.from_cs_lit", v, 32'h221);

        // dev_addr register read-back.
        apb_write(14, 8'hAA); apb_read(14, b); check("dev_addr_aa", b, 8'hAA);
        apb_write(14, 8'h98); apb_read(14, b); check("dev_addr_98", b, 8'h98);
        apb_write(12, 8'h05); apb_read(12, b); check("state_ro", b, 8'h00);

        // Randomized transactions against the model.
        for (int t = 0; t < 6; t++) begin
            q = q_tab[$urandom_range(0, 2)];
            if ($urandom_range(0, 3) == 0) begin
                b = 8'($urandom_range(8, 119)) << 1;
                apb_write(14, b);
                m_dev[7:0] = b;
            end
            if ($urandom_range(0, 1) == 1) begin
                b = 8'($urandom);
                apb_write(21, b);
                m_nfs = b;
            end
            if ($urandom_range(0, 4) == 0) a = 8'($urandom);
            else a = {m_dev[7:1], 1'($urandom_range(0, 1))};
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) data_buf[i] = 8'($urandom);
            if (a[0]) txn_read(a, n);
            else txn_write(a, n);
            check_regs("random");
        end

        // Non-matching address: nothing driven, later byte ignored.
        pulse_reset();
        q = q_tab[2];
        drive_seen = 1'b0;
        data_buf[0] = 8'($urandom);
        txn_write(8'h54, 1);
        check("nomatch_drive", drive_seen, 1'b0);
        check_regs("nomatch");

        // Reset in the middle of a read while SDA is being pulled low.
        apb_write(21, 8'h00);
        m_nfs = 8'h00;
        i2c_start();
        write_byte(8'h99, ack);
        check("midrd_addr_ack", ack, 1'b1);
        wait_clk(4);
        check("midrd_pre_drive", drive[0], 1'b1);
        rst = 1'b0;
        #1;
        check("midrd_rst_drive", drive[0], 1'b0);
        model_reset();
        check_regs("midrd");
        m_sda = 1'b1; wait_clk(q);
        m_scl = 1'b1; wait_clk(q);
        rst = 1'b1;
        wait_clk(5);

        // Bus-hold mode: SDA held low from START to STOP, no statistics.
        apb_write(16, 8'h00);
        m_tm = 1'b0;
        check("hold_idle_drive", drive[0], 1'b0);
        i2c_start();
        check("hold_drive", drive[0], 1'b1);
        read_byte(1'b1, b);
        check("hold_byte", b, 8'h00);
        i2c_stop();
        check("hold_release", drive[0], 1'b0);
        check_regs("hold");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
